// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM states and the
// operand-forwarding select encoding seen by the decode operand muxes.
package cpu_pipe_pkg;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        INT_ENTRY = 2'd1,
        FLUSH     = 2'd2
    } state_t;

    localparam logic [1:0] FWD_RF = 2'd0;
    localparam logic [1:0] FWD_EX = 2'd1;
    localparam logic [1:0] FWD_WB = 2'd2;

    localparam int CNT_W = 3;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle. The master side is the
// pipeline (decoder, EX, WB, interrupt source); the slave side is the controller.
interface pipeline_hazard_ctrl_if #(
    parameter int REG_ADDR_W = 5
);
    // No valid/ready pairs: every field is a per-cycle level sampled on each
    // rising clock edge, and int_req is a level held by its source until int_ack.
    logic [REG_ADDR_W-1:0] dec_a_addr;
    logic                  dec_a_rd;
    logic [REG_ADDR_W-1:0] dec_b_addr;
    logic                  dec_b_rd;
    logic [REG_ADDR_W-1:0] ex_wb_addr;
    logic                  ex_wb_en;
    logic                  ex_is_load;
    logic [REG_ADDR_W-1:0] wb_addr;
    logic                  wb_en;
    logic                  ex_branch;
    logic                  branch_taken;
    logic                  int_req;
    logic                  i_flag;

    logic [1:0]            fwd_a_sel;
    logic [1:0]            fwd_b_sel;
    logic                  pc_hold;
    logic                  fetch_stall;
    logic                  dec_nop;
    logic                  pc_mux_override;
    logic                  int_ack;
    logic                  busy;

    modport master (
        output dec_a_addr, dec_a_rd, dec_b_addr, dec_b_rd,
               ex_wb_addr, ex_wb_en, ex_is_load, wb_addr, wb_en,
               ex_branch, branch_taken, int_req, i_flag,
        input  fwd_a_sel, fwd_b_sel, pc_hold, fetch_stall, dec_nop,
               pc_mux_override, int_ack, busy
    );

    modport slave (
        input  dec_a_addr, dec_a_rd, dec_b_addr, dec_b_rd,
               ex_wb_addr, ex_wb_en, ex_is_load, wb_addr, wb_en,
               ex_branch, branch_taken, int_req, i_flag,
        output fwd_a_sel, fwd_b_sel, pc_hold, fetch_stall, dec_nop,
               pc_mux_override, int_ack, busy
    );

endinterface

// File: rtl/pipeline_hazard_ctrl_hazard_match.sv
// Combinational compare of one decode operand against the EX and WB
// destinations, producing the raw forwarding select for that operand.
module hazard_match
    import cpu_pipe_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int FWD_EN     = 1
) (
    input  logic [REG_ADDR_W-1:0] op_addr_i,
    input  logic                  op_rd_i,
    input  logic [REG_ADDR_W-1:0] ex_wb_addr_i,
    input  logic                  ex_wb_en_i,
    input  logic                  ex_is_load_i,
    input  logic [REG_ADDR_W-1:0] wb_addr_i,
    input  logic                  wb_en_i,
    output logic                  match_ex_o,
    output logic                  match_wb_o,
    output logic [1:0]            fwd_sel_o
);

    assign match_ex_o = op_rd_i & ex_wb_en_i & (ex_wb_addr_i == op_addr_i);
    assign match_wb_o = op_rd_i & wb_en_i    & (wb_addr_i    == op_addr_i);

    // A load in EX has no data yet, so it falls through to the WB compare.
    always_comb begin
        fwd_sel_o = FWD_RF;
        if (FWD_EN != 0) begin
            if (match_ex_o && !ex_is_load_i) begin
                fwd_sel_o = FWD_EX;
            end else if (match_wb_o) begin
                fwd_sel_o = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: forwarding selects, RAW/load-use stalls,
// taken-branch flush sequencing and interrupt entry with acknowledge.
module pipeline_hazard_ctrl
    import cpu_pipe_pkg::*;
#(
    parameter int REG_ADDR_W     = 5,
    parameter int FWD_EN         = 1,
    parameter int BRANCH_BUBBLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    pipeline_hazard_ctrl_if.slave  bus,
    output state_t                 dbg_state_o
);

    localparam logic [CNT_W-1:0] BUBBLES = CNT_W'(BRANCH_BUBBLES);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, pc_mux_q, int_ack_q;

    logic       a_ex, a_wb, b_ex, b_wb;
    logic [1:0] a_sel, b_sel;
    logic       take, raw_stall, stall, in_run;

    hazard_match #(.REG_ADDR_W(REG_ADDR_W), .FWD_EN(FWD_EN)) u_match_a (
        .op_addr_i    (bus.dec_a_addr),
        .op_rd_i      (bus.dec_a_rd),
        .ex_wb_addr_i (bus.ex_wb_addr),
        .ex_wb_en_i   (bus.ex_wb_en),
        .ex_is_load_i (bus.ex_is_load),
        .wb_addr_i    (bus.wb_addr),
        .wb_en_i      (bus.wb_en),
        .match_ex_o   (a_ex),
        .match_wb_o   (a_wb),
        .fwd_sel_o    (a_sel)
    );

    hazard_match #(.REG_ADDR_W(REG_ADDR_W), .FWD_EN(FWD_EN)) u_match_b (
        .op_addr_i    (bus.dec_b_addr),
        .op_rd_i      (bus.dec_b_rd),
        .ex_wb_addr_i (bus.ex_wb_addr),
        .ex_wb_en_i   (bus.ex_wb_en),
        .ex_is_load_i (bus.ex_is_load),
        .wb_addr_i    (bus.wb_addr),
        .wb_en_i      (bus.wb_en),
        .match_ex_o   (b_ex),
        .match_wb_o   (b_wb),
        .fwd_sel_o    (b_sel)
    );

    assign take   = bus.ex_branch & bus.branch_taken;
    assign in_run = (state_q == RUN);

    // Without forwarding any in-flight producer blocks decode until it retires.
    assign raw_stall = (FWD_EN != 0) ? (bus.ex_is_load & (a_ex | b_ex))
                                     : (a_ex | a_wb | b_ex | b_wb);
    assign stall     = in_run & raw_stall & ~take;

    assign bus.fwd_a_sel       = stall ? FWD_RF : a_sel;
    assign bus.fwd_b_sel       = stall ? FWD_RF : b_sel;
    assign bus.pc_hold         = stall;
    assign bus.fetch_stall     = stall;
    assign bus.dec_nop         = ~in_run | take | stall;
    assign bus.pc_mux_override = pc_mux_q;
    assign bus.int_ack         = int_ack_q;
    assign bus.busy            = busy_q;
    assign dbg_state_o         = state_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RUN: begin
                if (take) begin
                    state_d = FLUSH;
                    cnt_d   = BUBBLES;
                end else if (!raw_stall && bus.int_req && bus.i_flag) begin
                    state_d = INT_ENTRY;
                end
            end
            INT_ENTRY: begin
                state_d = FLUSH;
                cnt_d   = BUBBLES;
            end
            FLUSH: begin
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= RUN;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            pc_mux_q  <= 1'b0;
            int_ack_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            busy_q    <= (state_d != RUN);
            pc_mux_q  <= (state_d == INT_ENTRY);
            int_ack_q <= (state_q == INT_ENTRY);
        end
    end

endmodule
